// File: rtl/riscv_mc_controller_pkg.sv
// Purpose : shared encodings for the multicycle RV32I controller (opcodes, FSM states,
//           ALU op codes, datapath select codes) plus small branch-decode helpers.
// Latency : n/a (package). Backpressure: n/a.
package riscv_ctrl_pkg;

  // Base opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_e;

  // ALU operation codes; ADD must stay 0 so idle states present an all-zero bus.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // How the ALU decoder should interpret funct3/funct7 in the current state
  typedef enum logic [2:0] {AM_ADD, AM_SUB, AM_PASSB, AM_R, AM_I} alu_mode_e;

  localparam logic [1:0] WB_ALUOUT  = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic TRAP_ILLEGAL = 1'b0;
  localparam logic TRAP_TIMEOUT = 1'b1;

  // funct3 010/011 are unassigned in the branch major opcode
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  // comp[0]=equal, comp[1]=less-than (signedness resolved by the datapath)
  function automatic logic branch_taken(input logic [2:0] f3, input logic [1:0] comp);
    logic cond;
    cond = f3[2] ? comp[1] : comp[0];
    return cond ^ f3[0];
  endfunction

endpackage

// File: rtl/riscv_mc_controller_if.sv
// Purpose : IR fields, comparator/memory status in, datapath enables/selects out.
// Latency : n/a (wires only). Backpressure: mem_ready stalls the controller in wait states.
// Ports   : master = controller side (decodes IR, drives controls); slave = datapath side.
interface riscv_mc_controller_if #(
  parameter int ALUOP_W = 4
) ();
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [1:0]         comp;
  logic               mem_ready;

  logic               pc_write;
  logic               pc_src;
  logic               addr_src;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         wb_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_write;
  logic               trap;
  logic               trap_cause;

  modport master (
    input  opcode, funct3, funct7, comp, mem_ready,
    output pc_write, pc_src, addr_src, mem_read, mem_write, ir_write,
           wb_src, alu_src_a, alu_src_b, alu_op, reg_write, trap, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7, comp, mem_ready,
    input  pc_write, pc_src, addr_src, mem_read, mem_write, ir_write,
           wb_src, alu_src_a, alu_src_b, alu_op, reg_write, trap, trap_cause
  );
endinterface

// File: rtl/riscv_mc_controller_alu_op_dec.sv
// Purpose : combinational ALU decoder, (mode, funct3, funct7[5]) -> alu_op code.
// Latency : 0 cycles (pure combinational). Backpressure: none.
// Ports   : mode (state-selected interpretation), funct3, funct7_5 in; alu_op out.
module riscv_alu_op_dec
  import riscv_ctrl_pkg::*;
(
  input  alu_mode_e  mode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (mode)
      AM_ADD:   alu_op = ALU_ADD;
      AM_SUB:   alu_op = ALU_SUB;
      AM_PASSB: alu_op = ALU_PASSB;
      AM_R, AM_I: begin
        case (funct3)
          // funct7[5] selects SUB only for register-register; ADDI has no SUB form
          3'b000:  alu_op = (mode == AM_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Purpose : multicycle RV32I main controller FSM with memory wait/timeout and sticky trap.
// Latency : >=3 cycles per instruction (FETCH, DECODE, execute) plus memory wait states.
// Backpressure: holds mem_read/mem_write/addr_src steady until mem_ready; traps after TIMEOUT waits.
// Ports   : clk, rst (async, active high); bus = controller modport of riscv_mc_controller_if.
module riscv_mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ALUOP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_mc_controller_if.master  bus
);

  // Counter must hold values up to TIMEOUT-1; keep at least one bit when timeout is disabled
  localparam int              TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            cause_q, cause_d;

  logic            waiting;
  logic            timed_out;
  alu_mode_e       alu_mode;
  logic [3:0]      alu_op_raw;

  logic            pc_write, pc_src, addr_src, mem_read, mem_write, ir_write;
  logic [1:0]      wb_src, alu_src_a, alu_src_b;
  logic            reg_write, trap, trap_cause;

  // Only funct7[5] carries meaning for this ISA subset
  logic            unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  riscv_alu_op_dec u_alu_op_dec (
    .mode     (alu_mode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7[5]),
    .alu_op   (alu_op_raw)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    addr_src  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    wb_src    = WB_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    alu_mode  = AM_ADD;
    reg_write = 1'b0;
    trap      = 1'b0;
    trap_cause = 1'b0;
    waiting   = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      // PC+4 is computed while the fetch is outstanding; PC/IR latch on completion
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        waiting   = 1'b1;
        if (bus.mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end

      // oldPC+imm lands in ALUOut: branch/JAL target, or AUIPC result
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM, OPC_LUI: state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_AUIPC:           state_d = S_ALU_WB;
          OPC_JALR: begin
            if (bus.funct3 == 3'b000) begin
              state_d = S_JALR;
            end else begin
              state_d = S_TRAP;
              cause_d = TRAP_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = TRAP_ILLEGAL;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        addr_src = 1'b1;
        waiting  = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_src    = WB_MEM;
        state_d   = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        addr_src  = 1'b1;
        waiting   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end

      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_mode  = AM_R;
        state_d   = S_ALU_WB;
      end

      // LUI shares this state: the immediate is passed straight through
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_mode  = (bus.opcode == OPC_LUI) ? AM_PASSB : AM_I;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        wb_src    = WB_ALUOUT;
        state_d   = S_FETCH;
      end

      // Target was precomputed in DECODE; pc_write is the only data-dependent output
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_mode  = AM_SUB;
        pc_src    = 1'b1;
        if (branch_f3_legal(bus.funct3)) begin
          pc_write = branch_taken(bus.funct3, bus.comp);
          state_d  = S_FETCH;
        end else begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end
      end

      S_JAL: begin
        reg_write = 1'b1;
        wb_src    = WB_PC;
        pc_src    = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      // Link uses the register PC (already PC+4) before it is overwritten this cycle
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        pc_src    = 1'b0;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_src    = WB_PC;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end

      default: state_d = S_RST;
    endcase

    // Counter restarts whenever a wait state is entered or left
    cnt_d = (waiting && (state_d == state_q) && (TIMEOUT != 0)) ? (cnt_q + TO_W'(1)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.addr_src   = addr_src;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.wb_src     = wb_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = ALUOP_W'(alu_op_raw);
  assign bus.reg_write  = reg_write;
  assign bus.trap       = trap;
  assign bus.trap_cause = trap_cause;

endmodule
